// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default oversampling and baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE_DFLT = 16;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by restart.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop sync, 16x majority-vote framing, valid/ready holding register, rx LED.
// Define UART_PARITY_EN for 8E1 framing (even parity bit between D7 and stop).
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DFLT,
  parameter int unsigned LED_HOLD   = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       led_rx
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned LW = $clog2(LED_HOLD + 1);
  localparam logic [TW-1:0] T_LO  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HI  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

`ifdef UART_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  logic          rx_meta;
  logic          rxs;
  rx_state_t     state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          s_lo;
  logic          s_mid;
  logic          tick;
  logic          restart_c;
  logic          vote_c;
  logic          vote_pt_c;
  logic          bit_end_c;
  logic          par_ok_c;
  logic          byte_done_c;
  logic [LW-1:0] led_cnt;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart_c),
    .tick   (tick)
  );

  assign restart_c   = (state == IDLE) && !rxs;
  assign vote_c      = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
  assign vote_pt_c   = tick && (tick_cnt == T_HI);
  assign bit_end_c   = tick && (tick_cnt == T_END);
  assign byte_done_c = (state == STOP) && vote_pt_c && vote_c && par_ok_c;

`ifdef UART_PARITY_EN
  logic par_bit;
  assign par_ok_c = (par_bit == ^shreg);
`else
  assign par_ok_c   = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Synchroniser, bit timing and framing FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      s_lo      <= 1'b1;
      s_mid     <= 1'b1;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state != IDLE && tick) begin
        tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == T_LO)  s_lo  <= rxs;
        if (tick_cnt == T_MID) s_mid <= rxs;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (vote_pt_c && vote_c) begin
            state <= IDLE;
          end else if (bit_end_c) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (vote_pt_c) shreg <= {vote_c, shreg[7:1]};
          if (bit_end_c) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end
        end
        PARITY: begin
`ifdef UART_PARITY_EN
          if (vote_pt_c) par_bit <= vote_c;
          if (bit_end_c) state <= STOP;
`else
          state <= STOP;
`endif
        end
        STOP: begin
          // Re-arm at the stop vote so the next start edge is never missed.
          if (vote_pt_c) begin
`ifdef UART_PARITY_EN
            parity_err <= ~par_ok_c;
`endif
            if (vote_c) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register, overrun detection and LED stretcher.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      led_cnt  <= '0;
      led_rx   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (rx_valid && rx_ready) begin
        led_cnt <= LW'(LED_HOLD - 1);
        led_rx  <= 1'b1;
      end else if (led_cnt != '0) begin
        led_cnt <= led_cnt - 1'b1;
      end else begin
        led_rx <= 1'b0;
      end
    end
  end

endmodule
